lsu_dccm_bank_ctl: RTL and testbench



---
 rtl/lsu_dccm_bank_ctl_pkg.sv | 17 +
 rtl/lsu_dccm_starve_ctr.sv | 27 ++
 rtl/lsu_dccm_bank_ctl.sv | 182 ++++++++++++++++++
 tb/tb_lsu_dccm_bank_ctl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_dccm_bank_ctl_pkg.sv
// Shared DCCM definitions: default word geometry and the address-to-bank mapping.
package lsu_dccm_bank_ctl_pkg;

    localparam int DCCM_DATA_WIDTH = 32;
    localparam int DCCM_ECC_WIDTH  = 7;
    localparam int DCCM_FDATA      = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH;

    // Banks interleave on bank words; the byte offset inside a word is skipped.
    function automatic logic [3:0] dccm_bank_idx(input logic [31:0] addr,
                                                 input int          data_width,
                                                 input int          num_banks);
        logic [31:0] word_addr;
        word_addr = addr >> $clog2(data_width / 8);
        return 4'(word_addr & 32'(num_banks - 1));
    endfunction

endpackage

// File: rtl/lsu_dccm_starve_ctr.sv
// Counts consecutive commit attempts lost to loads; saturates and raises starve_force.
// Registered count, force is a same-cycle decode of it; clr wins over inc.
module lsu_dccm_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst_l,
    input  logic inc,
    input  logic clr,
    output logic starve_force
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != 4'(STARVE_MAX))) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign starve_force = (cnt == 4'(STARVE_MAX));

endmodule

// File: rtl/lsu_dccm_bank_ctl.sv
// Multi-bank DCCM port control: load/commit arbitration (same-cycle enables), 2-cycle read to DC3,
// freeze holds DC2/DC3 and blocks commits. Optional ECC scrub write-back under LSU_DCCM_SCRUB_EN.
module lsu_dccm_bank_ctl
    import lsu_dccm_bank_ctl_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = DCCM_DATA_WIDTH,
    parameter int ECC_WIDTH  = DCCM_ECC_WIDTH,
    parameter int ADDR_BITS  = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic                                      clk,
    input  logic                                      rst_l,
    input  logic                                      freeze_dc3,
    input  logic                                      ld_valid_dc1,
    input  logic [ADDR_BITS-1:0]                      ld_addr_lo_dc1,
    input  logic [ADDR_BITS-1:0]                      ld_addr_hi_dc1,
    output logic                                      ld_stall_dc1,
    input  logic                                      stbuf_req,
    input  logic [ADDR_BITS-1:0]                      stbuf_addr,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0]           stbuf_wdata,
    output logic                                      stbuf_commit,
    output logic [NUM_BANKS-1:0]                      dccm_rden,
    output logic [NUM_BANKS-1:0]                      dccm_wren,
    output logic [NUM_BANKS*ADDR_BITS-1:0]            dccm_addr,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0]           dccm_wdata,
    input  logic [NUM_BANKS*(DATA_WIDTH+ECC_WIDTH)-1:0] dccm_rdata,
    output logic                                      rd_valid_dc3,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0]           rd_data_lo_dc3,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0]           rd_data_hi_dc3,
    input  logic                                      sb_err_dc3,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0]           corr_data_dc3,
    input  logic [ADDR_BITS-1:0]                      corr_addr_dc3
);

    localparam int FD = DATA_WIDTH + ECC_WIDTH;
    localparam int BW = $clog2(NUM_BANKS);

    logic [BW-1:0] lo_bank, hi_bank, sb_bank;
    logic          conflict, starve_force, force_win, commit, starve_inc, ld_go;
    logic [NUM_BANKS-1:0] rd_oh, wr_oh;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [FD-1:0]        wr_data;
    logic [FD-1:0]        rdata_arr [NUM_BANKS];

    logic          scrub_go;
    logic [BW-1:0] scrub_bank;
    logic [FD-1:0] scrub_data;
    logic [ADDR_BITS-1:0] scrub_addr;

    assign lo_bank = BW'(dccm_bank_idx(32'(ld_addr_lo_dc1), DATA_WIDTH, NUM_BANKS));
    assign hi_bank = BW'(dccm_bank_idx(32'(ld_addr_hi_dc1), DATA_WIDTH, NUM_BANKS));
    assign sb_bank = BW'(dccm_bank_idx(32'(stbuf_addr), DATA_WIDTH, NUM_BANKS));

    // Outputs are qualified with rst_l so every enable reads 0 while reset is held.
    assign conflict   = ld_valid_dc1 & stbuf_req & ((sb_bank == lo_bank) | (sb_bank == hi_bank));
    assign force_win  = rst_l & ~freeze_dc3 & conflict & starve_force;
    assign commit     = rst_l & stbuf_req & ~freeze_dc3 & (~conflict | starve_force | ~ld_valid_dc1);
    assign starve_inc = rst_l & ~freeze_dc3 & conflict & ~starve_force;
    assign ld_go      = rst_l & ld_valid_dc1 & ~freeze_dc3 & ~force_win;

    lsu_dccm_starve_ctr #(
        .STARVE_MAX   (STARVE_MAX)
    ) u_starve_ctr (
        .clk          (clk),
        .rst_l        (rst_l),
        .inc          (starve_inc),
        .clr          (commit),
        .starve_force (starve_force)
    );

`ifdef LSU_DCCM_SCRUB_EN
    localparam int OFF = $clog2(DATA_WIDTH / 8);

    logic scrub_vld, scrub_ld_hit, scrub_kill;

    assign scrub_bank   = BW'(dccm_bank_idx(32'(scrub_addr), DATA_WIDTH, NUM_BANKS));
    assign scrub_ld_hit = ld_valid_dc1 & ((lo_bank == scrub_bank) | (hi_bank == scrub_bank));
    assign scrub_go     = rst_l & scrub_vld & ~stbuf_req & ~scrub_ld_hit;
    // A newer commit to the same word makes the corrected copy stale.
    assign scrub_kill   = commit & (stbuf_addr[ADDR_BITS-1:OFF] == scrub_addr[ADDR_BITS-1:OFF]);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            scrub_vld <= 1'b0;
        end else if (scrub_vld) begin
            if (scrub_go || scrub_kill) begin
                scrub_vld <= 1'b0;
            end
        end else if (sb_err_dc3 && !freeze_dc3) begin
            scrub_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!scrub_vld && sb_err_dc3 && !freeze_dc3) begin
            scrub_data <= corr_data_dc3;
            scrub_addr <= corr_addr_dc3;
        end
    end
`else
    logic scrub_unused;
    assign scrub_unused = ^{sb_err_dc3, corr_data_dc3, corr_addr_dc3};
    assign scrub_go     = 1'b0;
    assign scrub_bank   = '0;
    assign scrub_data   = '0;
    assign scrub_addr   = '0;
`endif

    assign rd_oh = ld_go ? ((NUM_BANKS'(1) << lo_bank) | (NUM_BANKS'(1) << hi_bank)) : '0;

    always_comb begin
        wr_oh   = '0;
        wr_addr = '0;
        wr_data = '0;
        if (commit) begin
            wr_oh   = NUM_BANKS'(1) << sb_bank;
            wr_addr = stbuf_addr;
            wr_data = stbuf_wdata;
        end else if (scrub_go) begin
            wr_oh   = NUM_BANKS'(1) << scrub_bank;
            wr_addr = scrub_addr;
            wr_data = scrub_data;
        end
    end

    // Read and write never target the same bank in one cycle, so the order here is moot.
    always_comb begin
        dccm_addr = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_oh[b]) begin
                dccm_addr[b*ADDR_BITS +: ADDR_BITS] = wr_addr;
            end
            if (rd_oh[b]) begin
                dccm_addr[b*ADDR_BITS +: ADDR_BITS] = (BW'(b) == lo_bank) ? ld_addr_lo_dc1
                                                                          : ld_addr_hi_dc1;
            end
        end
    end

    assign dccm_rden    = rd_oh;
    assign dccm_wren    = wr_oh;
    assign dccm_wdata   = wr_data;
    assign stbuf_commit = commit;
    assign ld_stall_dc1 = force_win;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_rdata
        assign rdata_arr[g] = dccm_rdata[g*FD +: FD];
    end

    logic          dc2_vld, dc3_vld;
    logic [BW-1:0] dc2_lo_bank, dc2_hi_bank;
    logic [FD-1:0] dc3_lo, dc3_hi;

    // Frozen cycles issue no reads, so the macro outputs stay on the word DC2 is waiting for.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            dc2_vld     <= 1'b0;
            dc2_lo_bank <= '0;
            dc2_hi_bank <= '0;
            dc3_vld     <= 1'b0;
            dc3_lo      <= '0;
            dc3_hi      <= '0;
        end else if (!freeze_dc3) begin
            dc2_vld <= ld_go;
            if (ld_go) begin
                dc2_lo_bank <= lo_bank;
                dc2_hi_bank <= hi_bank;
            end
            dc3_vld <= dc2_vld;
            if (dc2_vld) begin
                dc3_lo <= rdata_arr[dc2_lo_bank];
                dc3_hi <= rdata_arr[dc2_hi_bank];
            end
        end
    end

    assign rd_valid_dc3   = dc3_vld;
    assign rd_data_lo_dc3 = dc3_lo;
    assign rd_data_hi_dc3 = dc3_hi;

endmodule

// File: tb/tb_lsu_dccm_bank_ctl.sv
// Bench for lsu_dccm_bank_ctl: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_lsu_dccm_bank_ctl;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int EW = 7;
    localparam int AB = 16;
    localparam int SM = 3;
    localparam int FD = DW + EW;

    logic              clk = 1'b0;
    logic              rst_l;
    logic              freeze_dc3;
    logic              ld_valid_dc1;
    logic [AB-1:0]     ld_addr_lo_dc1, ld_addr_hi_dc1;
    logic              ld_stall_dc1;
    logic              stbuf_req;
    logic [AB-1:0]     stbuf_addr;
    logic [FD-1:0]     stbuf_wdata;
    logic              stbuf_commit;
    logic [NB-1:0]     dccm_rden, dccm_wren;
    logic [NB*AB-1:0]  dccm_addr;
    logic [FD-1:0]     dccm_wdata;
    logic [NB*FD-1:0]  dccm_rdata = '0;
    logic              rd_valid_dc3;
    logic [FD-1:0]     rd_data_lo_dc3, rd_data_hi_dc3;
    logic              sb_err_dc3;
    logic [FD-1:0]     corr_data_dc3;
    logic [AB-1:0]     corr_addr_dc3;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    lsu_dccm_bank_ctl #(
        .NUM_BANKS (NB), .DATA_WIDTH (DW), .ECC_WIDTH (EW), .ADDR_BITS (AB), .STARVE_MAX (SM)
    ) dut (
        .clk (clk), .rst_l (rst_l), .freeze_dc3 (freeze_dc3),
        .ld_valid_dc1 (ld_valid_dc1), .ld_addr_lo_dc1 (ld_addr_lo_dc1), .ld_addr_hi_dc1 (ld_addr_hi_dc1),
        .ld_stall_dc1 (ld_stall_dc1), .stbuf_req (stbuf_req), .stbuf_addr (stbuf_addr),
        .stbuf_wdata (stbuf_wdata), .stbuf_commit (stbuf_commit), .dccm_rden (dccm_rden),
        .dccm_wren (dccm_wren), .dccm_addr (dccm_addr), .dccm_wdata (dccm_wdata),
        .dccm_rdata (dccm_rdata), .rd_valid_dc3 (rd_valid_dc3), .rd_data_lo_dc3 (rd_data_lo_dc3),
        .rd_data_hi_dc3 (rd_data_hi_dc3), .sb_err_dc3 (sb_err_dc3), .corr_data_dc3 (corr_data_dc3),
        .corr_addr_dc3 (corr_addr_dc3)
    );

    // Word content a bank returns for a given address: unique per (bank, address).
    function automatic logic [FD-1:0] pat(input int b, input logic [AB-1:0] a);
        logic [6:0] bb;
        bb = 7'(b) ^ 7'h55;
        return {bb, a, ~a};
    endfunction

    function automatic int bk(input logic [AB-1:0] a);
        return (int'(a) / (DW / 8)) % NB;
    endfunction

    // Bank macro: registered read, output held until the next read of that bank.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (dccm_rden[b]) dccm_rdata[b*FD +: FD] <= pat(b, dccm_addr[b*AB +: AB]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        freeze_dc3 = 1'b0; ld_valid_dc1 = 1'b0; ld_addr_lo_dc1 = '0; ld_addr_hi_dc1 = '0;
        stbuf_req = 1'b0; stbuf_addr = '0; stbuf_wdata = '0;
        sb_err_dc3 = 1'b0; corr_data_dc3 = '0; corr_addr_dc3 = '0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0; idle();
        ld_valid_dc1 = 1'b1; ld_addr_lo_dc1 = 16'h0010; ld_addr_hi_dc1 = 16'h0010;
        stbuf_req = 1'b1; stbuf_addr = 16'h0014;
        repeat (3) tick();
        #3;
        vec++; if (dccm_rden !== 4'b0) begin errs++; $display("FAIL reset_rden got %b exp 0000", dccm_rden); end
        vec++; if (dccm_wren !== 4'b0) begin errs++; $display("FAIL reset_wren got %b exp 0000", dccm_wren); end
        vec++; if (stbuf_commit !== 1'b0) begin errs++; $display("FAIL reset_commit got %b exp 0", stbuf_commit); end
        vec++; if (ld_stall_dc1 !== 1'b0) begin errs++; $display("FAIL reset_stall got %b exp 0", ld_stall_dc1); end
        vec++; if (rd_valid_dc3 !== 1'b0) begin errs++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid_dc3); end
        vec++; if (rd_data_lo_dc3 !== '0) begin errs++; $display("FAIL reset_rd_lo got %h exp 0", rd_data_lo_dc3); end
        idle(); rst_l = 1'b1;
        tick();
    endtask

    task automatic test_parallel();
        idle();
        ld_valid_dc1 = 1'b1; ld_addr_lo_dc1 = 16'h0010; ld_addr_hi_dc1 = 16'h0010;
        stbuf_req = 1'b1; stbuf_addr = 16'h0014; stbuf_wdata = 39'h12_3456_789A;
        #3;
        vec++; if (dccm_rden !== 4'b0001) begin errs++; $display("FAIL par_rden got %b exp 0001", dccm_rden); end
        vec++; if (dccm_wren !== 4'b0010) begin errs++; $display("FAIL par_wren got %b exp 0010", dccm_wren); end
        vec++; if (stbuf_commit !== 1'b1) begin errs++; $display("FAIL par_commit got %b exp 1", stbuf_commit); end
        vec++; if (dccm_wdata !== 39'h12_3456_789A) begin errs++; $display("FAIL par_wdata got %h exp 123456789a", dccm_wdata); end
        vec++; if (dccm_addr[0*AB +: AB] !== 16'h0010) begin errs++; $display("FAIL par_addr0 got %h exp 0010", dccm_addr[0*AB +: AB]); end
        vec++; if (dccm_addr[1*AB +: AB] !== 16'h0014) begin errs++; $display("FAIL par_addr1 got %h exp 0014", dccm_addr[1*AB +: AB]); end
        tick(); idle();
        vec++; if (rd_valid_dc3 !== 1'b0) begin errs++; $display("FAIL par_valid_dc2 got %b exp 0", rd_valid_dc3); end
        tick();
        vec++; if (rd_valid_dc3 !== 1'b1) begin errs++; $display("FAIL par_valid_dc3 got %b exp 1", rd_valid_dc3); end
        vec++; if (rd_data_lo_dc3 !== pat(0, 16'h0010)) begin errs++; $display("FAIL par_lo got %h exp %h", rd_data_lo_dc3, pat(0, 16'h0010)); end
        vec++; if (rd_data_hi_dc3 !== pat(0, 16'h0010)) begin errs++; $display("FAIL par_hi got %h exp %h", rd_data_hi_dc3, pat(0, 16'h0010)); end
        tick();
    endtask

    task automatic test_starve();
        logic e_win;
        idle();
        ld_valid_dc1 = 1'b1; ld_addr_lo_dc1 = 16'h0010; ld_addr_hi_dc1 = 16'h0010;
        stbuf_req = 1'b1; stbuf_addr = 16'h0020; stbuf_wdata = 39'h0_0BAD_F00D;
        for (int i = 0; i < 2 * (SM + 1); i++) begin
            e_win = ((i % (SM + 1)) == SM);
            #3;
            vec++; if (stbuf_commit !== e_win) begin errs++; $display("FAIL starve_commit[%0d] got %b exp %b", i, stbuf_commit, e_win); end
            vec++; if (ld_stall_dc1 !== e_win) begin errs++; $display("FAIL starve_stall[%0d] got %b exp %b", i, ld_stall_dc1, e_win); end
            vec++; if (dccm_rden !== (e_win ? 4'b0000 : 4'b0001)) begin errs++; $display("FAIL starve_rden[%0d] got %b", i, dccm_rden); end
            vec++; if (dccm_wren !== (e_win ? 4'b0001 : 4'b0000)) begin errs++; $display("FAIL starve_wren[%0d] got %b", i, dccm_wren); end
            tick();
        end
        idle(); tick(); tick();
    endtask

    task automatic test_unaligned();
        idle();
        ld_valid_dc1 = 1'b1; ld_addr_lo_dc1 = 16'h001E; ld_addr_hi_dc1 = 16'h0021;
        #3;
        vec++; if (dccm_rden !== 4'b1001) begin errs++; $display("FAIL unal_rden got %b exp 1001", dccm_rden); end
        vec++; if (dccm_addr[3*AB +: AB] !== 16'h001E) begin errs++; $display("FAIL unal_addr3 got %h exp 001e", dccm_addr[3*AB +: AB]); end
        vec++; if (dccm_addr[0*AB +: AB] !== 16'h0021) begin errs++; $display("FAIL unal_addr0 got %h exp 0021", dccm_addr[0*AB +: AB]); end
        tick(); idle(); tick();
        vec++; if (rd_valid_dc3 !== 1'b1) begin errs++; $display("FAIL unal_valid got %b exp 1", rd_valid_dc3); end
        vec++; if (rd_data_lo_dc3 !== pat(3, 16'h001E)) begin errs++; $display("FAIL unal_lo got %h exp %h", rd_data_lo_dc3, pat(3, 16'h001E)); end
        vec++; if (rd_data_hi_dc3 !== pat(0, 16'h0021)) begin errs++; $display("FAIL unal_hi got %h exp %h", rd_data_hi_dc3, pat(0, 16'h0021)); end
        tick();
    endtask

    task automatic test_freeze();
        idle();
        ld_valid_dc1 = 1'b1; ld_addr_lo_dc1 = 16'h0010; ld_addr_hi_dc1 = 16'h0010;
        tick();
        ld_addr_lo_dc1 = 16'h0034; ld_addr_hi_dc1 = 16'h0034;
        tick();
        idle(); freeze_dc3 = 1'b1; stbuf_req = 1'b1; stbuf_addr = 16'h0028; stbuf_wdata = 39'h1_1111_1111;
        for (int i = 0; i < 5; i++) begin
            #3;
            vec++; if (rd_valid_dc3 !== 1'b1) begin errs++; $display("FAIL frz_valid[%0d] got %b exp 1", i, rd_valid_dc3); end
            vec++; if (rd_data_lo_dc3 !== pat(0, 16'h0010)) begin errs++; $display("FAIL frz_lo[%0d] got %h exp %h", i, rd_data_lo_dc3, pat(0, 16'h0010)); end
            vec++; if (stbuf_commit !== 1'b0) begin errs++; $display("FAIL frz_commit[%0d] got %b exp 0", i, stbuf_commit); end
            vec++; if (dccm_wren !== 4'b0) begin errs++; $display("FAIL frz_wren[%0d] got %b exp 0000", i, dccm_wren); end
            tick();
        end
        idle();
        #3;
        vec++; if (rd_data_lo_dc3 !== pat(0, 16'h0010)) begin errs++; $display("FAIL frz_release_lo got %h exp %h", rd_data_lo_dc3, pat(0, 16'h0010)); end
        tick();
        vec++; if (rd_valid_dc3 !== 1'b1) begin errs++; $display("FAIL frz_second_valid got %b exp 1", rd_valid_dc3); end
        vec++; if (rd_data_lo_dc3 !== pat(1, 16'h0034)) begin errs++; $display("FAIL frz_second_lo got %h exp %h", rd_data_lo_dc3, pat(1, 16'h0034)); end
        vec++; if (rd_data_hi_dc3 !== pat(1, 16'h0034)) begin errs++; $display("FAIL frz_second_hi got %h exp %h", rd_data_hi_dc3, pat(1, 16'h0034)); end
        tick();
    endtask

    task automatic test_reset_inflight();
        idle();
        ld_valid_dc1 = 1'b1; ld_addr_lo_dc1 = 16'h0010; ld_addr_hi_dc1 = 16'h0010;
        tick();
        idle(); rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        vec++; if (rd_valid_dc3 !== 1'b0) begin errs++; $display("FAIL rst_inflight_a got %b exp 0", rd_valid_dc3); end
        tick();
        vec++; if (rd_valid_dc3 !== 1'b0) begin errs++; $display("FAIL rst_inflight_b got %b exp 0", rd_valid_dc3); end
        // Two lost attempts, then reset: the guard must need a full STARVE_MAX losses again.
        ld_valid_dc1 = 1'b1; ld_addr_lo_dc1 = 16'h0010; ld_addr_hi_dc1 = 16'h0010;
        stbuf_req = 1'b1; stbuf_addr = 16'h0020;
        repeat (2) tick();
        rst_l = 1'b0; tick(); rst_l = 1'b1;
        for (int i = 0; i <= SM; i++) begin
            #3;
            vec++; if (stbuf_commit !== (i == SM)) begin errs++; $display("FAIL rst_starve[%0d] got %b exp %b", i, stbuf_commit, i == SM); end
            tick();
        end
        idle(); tick(); tick();
    endtask

`ifdef LSU_DCCM_SCRUB_EN
    task automatic test_scrub();
        idle();
        sb_err_dc3 = 1'b1; corr_addr_dc3 = 16'h0040; corr_data_dc3 = 39'h5_AAAA_0001;
        tick(); idle();
        #3;
        vec++; if (dccm_wren !== 4'b0001) begin errs++; $display("FAIL scrub_wren got %b exp 0001", dccm_wren); end
        vec++; if (dccm_wdata !== 39'h5_AAAA_0001) begin errs++; $display("FAIL scrub_wdata got %h", dccm_wdata); end
        vec++; if (dccm_addr[0 +: AB] !== 16'h0040) begin errs++; $display("FAIL scrub_addr got %h exp 0040", dccm_addr[0 +: AB]); end
        tick();
        #3;
        vec++; if (dccm_wren !== 4'b0) begin errs++; $display("FAIL scrub_done got %b exp 0000", dccm_wren); end
        tick();
        sb_err_dc3 = 1'b1; corr_addr_dc3 = 16'h0040; corr_data_dc3 = 39'h5_AAAA_0002;
        tick();
        corr_addr_dc3 = 16'h0044; corr_data_dc3 = 39'h5_AAAA_0003;
        ld_valid_dc1 = 1'b1; ld_addr_lo_dc1 = 16'h0050; ld_addr_hi_dc1 = 16'h0050;
        #3;
        vec++; if (dccm_wren !== 4'b0) begin errs++; $display("FAIL scrub_blocked got %b exp 0000", dccm_wren); end
        tick(); idle();
        #3;
        vec++; if (dccm_wren !== 4'b0001) begin errs++; $display("FAIL scrub_kept_wren got %b exp 0001", dccm_wren); end
        vec++; if (dccm_wdata !== 39'h5_AAAA_0002) begin errs++; $display("FAIL scrub_kept_data got %h", dccm_wdata); end
        tick();
        #3;
        vec++; if (dccm_wren !== 4'b0) begin errs++; $display("FAIL scrub_dropped got %b exp 0000", dccm_wren); end
        tick();
        sb_err_dc3 = 1'b1; corr_addr_dc3 = 16'h0080; corr_data_dc3 = 39'h5_AAAA_0004;
        tick(); idle();
        stbuf_req = 1'b1; stbuf_addr = 16'h0080; stbuf_wdata = 39'h2_2222_2222;
        #3;
        vec++; if (dccm_wdata !== 39'h2_2222_2222) begin errs++; $display("FAIL scrub_supersede_data got %h", dccm_wdata); end
        tick(); idle();
        #3;
        vec++; if (dccm_wren !== 4'b0) begin errs++; $display("FAIL scrub_superseded got %b exp 0000", dccm_wren); end
        tick(); tick();
    endtask
`endif

    task automatic test_random();
        int            starve;
        bit            hv0, hv1, clash, e_commit, e_stall, e_ld;
        logic [FD-1:0] hlo0, hhi0, hlo1, hhi1;
        logic [AB-1:0] lo, hi, sa;
        logic [NB-1:0] e_rden, e_wren;
        int            lb, hb, sb;
        starve = 0; hv0 = 0; hv1 = 0; hlo0 = '0; hhi0 = '0; hlo1 = '0; hhi1 = '0;
        idle(); rst_l = 1'b0; tick(); rst_l = 1'b1;
        for (int n = 0; n < 400; n++) begin
            vec++; if (rd_valid_dc3 !== hv1) begin errs++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, rd_valid_dc3, hv1); end
            if (hv1) begin
                vec++; if (rd_data_lo_dc3 !== hlo1) begin errs++; $display("FAIL rnd_lo[%0d] got %h exp %h", n, rd_data_lo_dc3, hlo1); end
                vec++; if (rd_data_hi_dc3 !== hhi1) begin errs++; $display("FAIL rnd_hi[%0d] got %h exp %h", n, rd_data_hi_dc3, hhi1); end
            end
            lo = 16'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0:       hi = lo;
                1:       hi = lo + 16'd1;
                default: hi = lo + 16'd3;
            endcase
            sa = 16'($urandom_range(0, 63) * 4);
            ld_valid_dc1 = ($urandom_range(0, 3) != 0);
            ld_addr_lo_dc1 = lo; ld_addr_hi_dc1 = hi;
            stbuf_req = ($urandom_range(0, 2) != 0);
            stbuf_addr = sa; stbuf_wdata = {7'($urandom), 32'($urandom)};
            lb = bk(lo); hb = bk(hi); sb = bk(sa);
            clash    = ld_valid_dc1 && stbuf_req && (sb == lb || sb == hb);
            e_stall  = clash && (starve == SM);
            e_commit = stbuf_req && (!clash || starve == SM);
            e_ld     = ld_valid_dc1 && !e_stall;
            e_rden   = e_ld ? NB'((1 << lb) | (1 << hb)) : '0;
            e_wren   = e_commit ? NB'(1 << sb) : '0;
            #3;
            vec++; if (stbuf_commit !== e_commit) begin errs++; $display("FAIL rnd_commit[%0d] got %b exp %b", n, stbuf_commit, e_commit); end
            vec++; if (ld_stall_dc1 !== e_stall) begin errs++; $display("FAIL rnd_stall[%0d] got %b exp %b", n, ld_stall_dc1, e_stall); end
            vec++; if (dccm_rden !== e_rden) begin errs++; $display("FAIL rnd_rden[%0d] got %b exp %b", n, dccm_rden, e_rden); end
            vec++; if (dccm_wren !== e_wren) begin errs++; $display("FAIL rnd_wren[%0d] got %b exp %b", n, dccm_wren, e_wren); end
            if (e_commit) begin
                vec++; if (dccm_wdata !== stbuf_wdata) begin errs++; $display("FAIL rnd_wdata[%0d] got %h exp %h", n, dccm_wdata, stbuf_wdata); end
                vec++; if (dccm_addr[sb*AB +: AB] !== sa) begin errs++; $display("FAIL rnd_waddr[%0d] got %h exp %h", n, dccm_addr[sb*AB +: AB], sa); end
            end
            if (e_commit) starve = 0;
            else if (clash && starve < SM) starve++;
            hv1 = hv0; hlo1 = hlo0; hhi1 = hhi0;
            hv0 = e_ld; hlo0 = pat(lb, lo); hhi0 = pat(hb, (hb == lb) ? lo : hi);
            tick();
        end
        idle(); tick(); tick();
    endtask

    initial begin
        rst_l = 1'b0;
        idle();
        tick();
        test_reset();
        test_parallel();
        test_starve();
        test_unaligned();
        test_freeze();
        test_reset_inflight();
`ifdef LSU_DCCM_SCRUB_EN
        test_scrub();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
